// File: rtl/prng_pkg.sv
// Shared types and constants for controllers that sequence the Trivium PRNG.
package prng_pkg;

    typedef logic [63:0] prng_word_t;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2
    } prng_ctrl_state_t;

    localparam prng_word_t PRNG_SEED_INIT = 64'h0123_4567_89AB_CDEF;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational find-first-from-pointer, registered pointer.
// The pointer advances past the winner only when the caller accepts the grant.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic               grant_any
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] winner;

    // Search indices >= ptr first, then wrap around to indices below ptr.
    always_comb begin
        grant_oh  = '0;
        grant_any = 1'b0;
        winner    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_any && req[i] && (i >= int'(ptr))) begin
                grant_any   = 1'b1;
                winner      = PW'(i);
                grant_oh[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_any && req[i] && (i < int'(ptr))) begin
                grant_any   = 1'b1;
                winner      = PW'(i);
                grant_oh[i] = 1'b1;
            end
        end
    end

    // Pointer moves to the slot after the winner, wrapping at NUM_REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (enable && grant_any) begin
            if (winner == PW'(NUM_REQ - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= winner + 1'b1;
            end
        end
    end

endmodule

// File: rtl/prng_share_ctrl.sv
// Sequencer/arbiter for the shared 64-bit Trivium PRNG.
// Loads the seed, waits out warm-up, then hands one fresh word per cycle to one
// requester in round-robin order. Handles external and periodic reseeding.
//
// Handshake: req is a level; a requester sees gnt[i] high for one cycle with
// rnd_data valid in that same cycle. There is no back-pressure: a grant is a
// delivery. The word delivered is the prng_data present in the cycle before gnt.
module prng_share_ctrl
    import prng_pkg::*;
#(
    parameter int          NUM_REQ         = 4,
    parameter prng_word_t  SEED_INIT       = PRNG_SEED_INIT,
    parameter int unsigned RESEED_INTERVAL = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               prng_rst,
    output prng_word_t         prng_seed,
    input  prng_word_t         prng_data,
    input  logic               prng_valid,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output prng_word_t         rnd_data,
    input  logic               reseed_req,
    input  prng_word_t         reseed_val,
    output logic               busy,
    output logic [31:0]        words_served
);

    localparam bit          AUTO_EN  = (RESEED_INTERVAL != 0);
    localparam logic [31:0] INTERVAL = 32'(RESEED_INTERVAL);

    prng_ctrl_state_t   state;
    prng_ctrl_state_t   next_state;
    prng_word_t         seed_reg;
    logic               arb_en;
    logic               arb_win;
    logic               auto_hit;
    logic               load_pulse;
    logic [NUM_REQ-1:0] grant_oh;
    logic               grant_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .enable    (arb_en),
        .grant_oh  (grant_oh),
        .grant_any (grant_any)
    );

    assign arb_win   = arb_en && grant_any;
    assign auto_hit  = AUTO_EN && arb_win && ((words_served + 32'd1) == INTERVAL);
    assign prng_seed = seed_reg;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a reseed request overrides everything else.
    // In WARM, a prng_valid that coincides with the seed-load pulse is stale
    // (left over from the previous seed) and is ignored.
    always_comb begin
        next_state = state;
        if (reseed_req) begin
            next_state = LOAD;
        end else begin
            case (state)
                LOAD: next_state = WARM;
                WARM: if (prng_valid && !prng_rst) next_state = RUN;
                RUN: begin
                    if (!prng_valid) begin
                        next_state = WARM;
                    end else if (auto_hit) begin
                        next_state = LOAD;
                    end
                end
                default: next_state = LOAD;
            endcase
        end
    end

    // FSM outputs; load_pulse is suppressed when a reseed restarts LOAD so the
    // adapter only ever sees one pulse, carrying the newest seed.
    always_comb begin
        busy       = (state != RUN);
        arb_en     = (state == RUN) && prng_valid && !reseed_req;
        load_pulse = (state == LOAD) && !reseed_req;
    end

    // Seed register: external reseed wins over the auto-increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed_reg <= SEED_INIT;
        end else if (reseed_req) begin
            seed_reg <= reseed_val;
        end else if (auto_hit) begin
            seed_reg <= seed_reg + 64'd1;
        end
    end

    // Registered grant, word, seed-load pulse and served-word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prng_rst     <= 1'b0;
            gnt          <= '0;
            rnd_data     <= '0;
            words_served <= '0;
        end else begin
            prng_rst <= load_pulse;
            gnt      <= arb_win ? grant_oh : '0;
            if (arb_win) begin
                rnd_data <= prng_data;
            end
            if (state == LOAD) begin
                words_served <= '0;
            end else if (arb_win) begin
                words_served <= words_served + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_prng_share_ctrl.sv
// Directed bench for prng_share_ctrl: one instance without auto-reseed and one
// with RESEED_INTERVAL = 3, each fed by a simple warm-up model of the adapter.
module tb_prng_share_ctrl;
    import prng_pkg::*;

    localparam prng_word_t SEED0 = 64'h0123_4567_89AB_CDEF;
    localparam prng_word_t K_MIX = 64'h9E37_79B9_7F4A_7C15;
    localparam prng_word_t SEED_DB = 64'h0000_0000_DEAD_BEEF;
    localparam prng_word_t SEED_CF = 64'hCAFE_F00D_1234_5678;

    // Clock and reset.
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals.
    logic        prng_rst, prng_valid, reseed_req, busy;
    prng_word_t  prng_seed, prng_data, rnd_data, reseed_val;
    logic [3:0]  req, gnt;
    logic [31:0] words_served;

    // Auto-reseed instance signals.
    logic        a_prng_rst, a_prng_valid, a_reseed_req, a_busy;
    prng_word_t  a_prng_seed, a_rnd_data, a_reseed_val;
    logic [3:0]  a_req, a_gnt;
    logic [31:0] a_words_served;

    // Adapter models.
    prng_word_t  data_ctr = 64'd1;
    int unsigned warm_cnt, a_warm_cnt;
    logic        valid_q, a_valid_q, kill;

    int checks = 0;
    int errors = 0;
    int n;
    int bad;
    prng_word_t exp_d;
    prng_word_t bench_w [8];
    prng_word_t obs_w [8];
    logic [3:0] rr_seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                               4'b0001, 4'b0010, 4'b0100, 4'b1000};

    prng_share_ctrl #(.NUM_REQ(4), .SEED_INIT(SEED0), .RESEED_INTERVAL(0)) dut (
        .clk(clk), .rst_n(rst_n), .prng_rst(prng_rst), .prng_seed(prng_seed),
        .prng_data(prng_data), .prng_valid(prng_valid), .req(req), .gnt(gnt),
        .rnd_data(rnd_data), .reseed_req(reseed_req), .reseed_val(reseed_val),
        .busy(busy), .words_served(words_served)
    );

    prng_share_ctrl #(.NUM_REQ(4), .SEED_INIT(SEED0), .RESEED_INTERVAL(3)) dut_ar (
        .clk(clk), .rst_n(rst_n), .prng_rst(a_prng_rst), .prng_seed(a_prng_seed),
        .prng_data(prng_data), .prng_valid(a_prng_valid), .req(a_req), .gnt(a_gnt),
        .rnd_data(a_rnd_data), .reseed_req(a_reseed_req), .reseed_val(a_reseed_val),
        .busy(a_busy), .words_served(a_words_served)
    );

    // Word stream: odd-constant multiply of a counter, so every cycle differs.
    always @(posedge clk) data_ctr <= data_ctr + 64'd1;
    assign prng_data    = data_ctr * K_MIX;
    assign prng_valid   = valid_q & ~kill;
    assign a_prng_valid = a_valid_q;

    // Warm-up model: prng_valid rises 19 cycles after the prng_rst cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_cnt <= 0;
            valid_q  <= 1'b0;
        end else if (prng_rst) begin
            warm_cnt <= 1;
            valid_q  <= 1'b0;
        end else if (warm_cnt != 0 && warm_cnt < 19) begin
            warm_cnt <= warm_cnt + 1;
            if (warm_cnt == 18) valid_q <= 1'b1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_warm_cnt <= 0;
            a_valid_q  <= 1'b0;
        end else if (a_prng_rst) begin
            a_warm_cnt <= 1;
            a_valid_q  <= 1'b0;
        end else if (a_warm_cnt != 0 && a_warm_cnt < 19) begin
            a_warm_cnt <= a_warm_cnt + 1;
            if (a_warm_cnt == 18) a_valid_q <= 1'b1;
        end
    end

    // Driver tasks.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Step until the chosen instance grants (max 60 cycles); reports steps taken
    // and the prng_data of the cycle before the grant.
    task automatic wait_grant(input bit on_ar, output int steps, output prng_word_t last_d);
        steps  = 0;
        last_d = '0;
        for (int k = 1; k <= 60; k++) begin
            last_d = prng_data;
            step();
            steps = k;
            if ((on_ar ? a_gnt : gnt) != 4'b0000) break;
        end
    endtask

    task automatic wait_busy_low(output int steps);
        steps = 0;
        for (int k = 1; k <= 60; k++) begin
            step();
            steps = k;
            if (!busy) break;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Directed sequence.
    initial begin
        req = 4'b0000; reseed_req = 1'b0; reseed_val = '0; kill = 1'b0;
        a_req = 4'b0000; a_reseed_req = 1'b0; a_reseed_val = '0;

        // Reset values.
        step(); step();
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_rnd", rnd_data, 64'd0);
        chk("rst_ws", 64'(words_served), 64'd0);
        chk("rst_prng_rst", 64'(prng_rst), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_seed", prng_seed, SEED0);

        // Release: one-cycle load pulse, then warm-up.
        rst_n = 1'b1;
        step();
        chk("start_pulse", 64'(prng_rst), 64'd1);
        chk("start_seed", prng_seed, SEED0);
        chk("start_pulse_ar", 64'(a_prng_rst), 64'd1);
        step();
        chk("start_pulse_end", 64'(prng_rst), 64'd0);
        chk("start_busy", 64'(busy), 64'd1);
        bad = 0;
        for (int i = 3; i <= 20; i++) begin
            step();
            if (busy !== 1'b1 || gnt !== 4'b0000) bad++;
        end
        chk("warm_busy_nognt", 64'(bad), 64'd0);
        step();
        chk("run_busy", 64'(busy), 64'd0);
        chk("run_busy_ar", 64'(a_busy), 64'd0);

        // Full contention: strict rotation, each word from the previous cycle.
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            bench_w[i] = prng_data;
            step();
            chk($sformatf("rr_gnt%0d", i), 64'(gnt), 64'(rr_seq[i]));
            chk($sformatf("rr_rnd%0d", i), rnd_data, bench_w[i]);
            obs_w[i] = rnd_data;
            if (i == 7) req = 4'b0000;
        end
        chk("rr_ws", 64'(words_served), 64'd8);
        bad = 0;
        for (int i = 0; i < 8; i++)
            for (int j = i + 1; j < 8; j++)
                if (obs_w[i] === obs_w[j]) bad++;
        chk("rr_distinct", 64'(bad), 64'd0);
        step();
        chk("idle_gnt", 64'(gnt), 64'd0);
        chk("idle_rnd_hold", rnd_data, bench_w[7]);

        // Single requester, then pointer check with two requesters.
        req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            exp_d = prng_data;
            step();
            chk("single_gnt", 64'(gnt), 64'h4);
            chk("single_ws", 64'(words_served), 64'(9 + i));
            chk("single_rnd", rnd_data, exp_d);
        end
        req = 4'b1001;
        step();
        chk("ptr3_gnt", 64'(gnt), 64'h8);
        step();
        chk("ptr0_gnt", 64'(gnt), 64'h1);
        chk("ptr0_ws", 64'(words_served), 64'd13);
        req = 4'b0000;
        step();
        chk("drop_gnt", 64'(gnt), 64'd0);

        // External reseed in RUN with requests pending.
        req = 4'b1111; reseed_req = 1'b1; reseed_val = SEED_DB;
        step();
        reseed_req = 1'b0;
        chk("rs_nognt", 64'(gnt), 64'd0);
        chk("rs_seed", prng_seed, SEED_DB);
        chk("rs_busy", 64'(busy), 64'd1);
        chk("rs_nopulse_yet", 64'(prng_rst), 64'd0);
        step();
        chk("rs_pulse", 64'(prng_rst), 64'd1);
        chk("rs_ws_clr", 64'(words_served), 64'd0);
        chk("rs_pulse_nognt", 64'(gnt), 64'd0);
        step();
        chk("rs_pulse_end", 64'(prng_rst), 64'd0);
        chk("rs_stale_valid_busy", 64'(busy), 64'd1);
        wait_grant(1'b0, n, exp_d);
        req = 4'b0001; kill = 1'b1;
        chk("rs_resume_steps", 64'(n), 64'd20);
        chk("rs_resume_gnt", 64'(gnt), 64'h2);
        chk("rs_resume_ws", 64'(words_served), 64'd1);
        chk("rs_resume_rnd", rnd_data, exp_d);

        // prng_valid drops in RUN: back to WARM, seed and pointer kept.
        step();
        kill = 1'b0;
        chk("vdrop_nognt", 64'(gnt), 64'd0);
        chk("vdrop_busy", 64'(busy), 64'd1);
        step();
        chk("vback_busy", 64'(busy), 64'd0);
        chk("vback_nognt", 64'(gnt), 64'd0);
        step();
        req = 4'b0000;
        chk("vback_gnt", 64'(gnt), 64'h1);
        chk("vback_ws", 64'(words_served), 64'd2);
        chk("vback_seed", prng_seed, SEED_DB);

        // Auto-reseed every 3 words.
        a_req = 4'b0001;
        step();
        chk("ar_g1", 64'(a_gnt), 64'h1);
        chk("ar_ws1", 64'(a_words_served), 64'd1);
        step();
        chk("ar_ws2", 64'(a_words_served), 64'd2);
        step();
        chk("ar_g3", 64'(a_gnt), 64'h1);
        chk("ar_ws3", 64'(a_words_served), 64'd3);
        chk("ar_seed1", a_prng_seed, SEED0 + 64'd1);
        chk("ar_busy", 64'(a_busy), 64'd1);
        step();
        chk("ar_pulse1", 64'(a_prng_rst), 64'd1);
        chk("ar_ws_clr", 64'(a_words_served), 64'd0);
        chk("ar_pulse_nognt", 64'(a_gnt), 64'd0);
        wait_grant(1'b1, n, exp_d);
        chk("ar_resume_steps", 64'(n), 64'd21);
        chk("ar_resume_ws", 64'(a_words_served), 64'd1);
        chk("ar_resume_rnd", a_rnd_data, exp_d);
        step();
        step();
        chk("ar_ws3b", 64'(a_words_served), 64'd3);
        chk("ar_seed2", a_prng_seed, SEED0 + 64'd2);
        step();
        chk("ar_pulse2", 64'(a_prng_rst), 64'd1);
        wait_grant(1'b1, n, exp_d);
        chk("ar_resume2_steps", 64'(n), 64'd21);
        step();
        chk("ar_ws2c", 64'(a_words_served), 64'd2);
        a_reseed_req = 1'b1; a_reseed_val = SEED_CF;
        step();
        a_reseed_req = 1'b0; a_req = 4'b0000;
        chk("ar_ovr_nognt", 64'(a_gnt), 64'd0);
        chk("ar_ovr_seed", a_prng_seed, SEED_CF);
        chk("ar_ovr_ws", 64'(a_words_served), 64'd2);
        step();
        chk("ar_ovr_pulse", 64'(a_prng_rst), 64'd1);

        // Asynchronous reset in the middle of a grant.
        req = 4'b0010;
        step();
        chk("pre_rst_gnt", 64'(gnt), 64'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_gnt", 64'(gnt), 64'd0);
        chk("arst_rnd", rnd_data, 64'd0);
        chk("arst_ws", 64'(words_served), 64'd0);
        chk("arst_busy", 64'(busy), 64'd1);
        step();
        rst_n = 1'b1; req = 4'b0000;
        step();
        chk("re_pulse", 64'(prng_rst), 64'd1);
        chk("re_seed", prng_seed, SEED0);
        step();
        chk("re_pulse_end", 64'(prng_rst), 64'd0);
        wait_busy_low(n);
        chk("re_warm_steps", 64'(n), 64'd19);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
